// File: rtl/vip_csc_pkg.sv
// Shared types and constants for the VIP RGB->YCbCr colour-space converter.
package vip_csc_pkg;

  localparam int unsigned CSC_FRAC = 8;
  localparam int unsigned CSC_LAT  = 4;

  typedef enum logic [1:0] {
    MODE_601  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_709  = 2'd2,
    MODE_BYP  = 2'd3
  } csc_mode_e;

  typedef logic signed [CSC_FRAC+1:0] coef_t;

  // [standard: 0=BT.601, 1=BT.709][row: Y, Cb, Cr][column: R, G, B], Q.8
  localparam coef_t COEF [2][3][3] = '{
    '{ '{ 10'sd77,   10'sd150,  10'sd29  },
       '{ -10'sd43,  -10'sd85,  10'sd128 },
       '{ 10'sd128,  -10'sd107, -10'sd21 } },
    '{ '{ 10'sd54,   10'sd183,  10'sd18  },
       '{ -10'sd29,  -10'sd99,  10'sd128 },
       '{ 10'sd128,  -10'sd116, -10'sd12 } }
  };

endpackage

// File: rtl/vip_csc_row.sv
// One output component: three signed products, offset/round sum, shift and clamp.
// Three register stages from inputs to y_o.
module vip_csc_row #(
  parameter int DW   = 8,
  parameter int FRAC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          r_i,
  input  logic [DW-1:0]          g_i,
  input  logic [DW-1:0]          b_i,
  input  logic signed [FRAC+1:0] c0_i,
  input  logic signed [FRAC+1:0] c1_i,
  input  logic signed [FRAC+1:0] c2_i,
  input  logic                   ofs_en_i,
  output logic [DW-1:0]          y_o
);

  localparam int SW = DW + FRAC + 3;
  localparam logic signed [SW-1:0] RND  = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] OFS  = SW'(1) << (DW - 1 + FRAC);
  localparam logic signed [SW-1:0] YMAX = SW'((1 << DW) - 1);

  logic signed [DW:0]   rs, gs, bs;
  logic signed [SW-1:0] p0_d, p1_d, p2_d, p0_q, p1_q, p2_q;
  logic signed [SW-1:0] sum_d, sum_q, sh;
  logic [DW-1:0]        y_d, y_q;

  // Products, sum and clamp next-state logic.
  always_comb begin
    rs    = {1'b0, r_i};
    gs    = {1'b0, g_i};
    bs    = {1'b0, b_i};
    p0_d  = SW'(rs) * SW'(c0_i);
    p1_d  = SW'(gs) * SW'(c1_i);
    p2_d  = SW'(bs) * SW'(c2_i);
    sum_d = p0_q + p1_q + p2_q + (ofs_en_i ? OFS : '0) + RND;
    sh    = sum_q >>> FRAC;
    y_d   = sh[DW-1:0];
    if (sh[SW-1])
      y_d = '0;
    else if (sh > YMAX)
      y_d = '1;
  end

  // Three pipeline stages: products, sum, clamped result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      sum_q <= '0;
      y_q   <= '0;
    end else begin
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      sum_q <= sum_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/vip_rgb_ycbcr_csc.sv
// RGB->YCbCr converter top: frame-aligned mode shadow, sync delay lines, output mux.
module vip_rgb_ycbcr_csc
  import vip_csc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = CSC_FRAC,
  parameter int LAT  = CSC_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      cfg_mode,
  input  logic            per_frame_vsync,
  input  logic            per_frame_href,
  input  logic            per_frame_clken,
  input  logic [3*DW-1:0] per_img_rgb,
  output logic            post_frame_vsync,
  output logic            post_frame_href,
  output logic            post_frame_clken,
  output logic [3*DW-1:0] post_img_data,
  output logic [1:0]      act_mode,
  output logic            mode_pending
);

  logic            vsync_q;
  csc_mode_e       act_d, act_q;
  logic            pend_q;
  logic            std_sel;
  csc_mode_e       m1_q, m2_q, m3_q;
  logic [3*DW-1:0] rgb1_q, rgb2_q, rgb3_q;
  logic [LAT-1:0]  vs_q, hr_q, ce_q;
  logic [DW-1:0]   y_w, cb_w, cr_w;
  logic [3*DW-1:0] data_d, data_q;

  // Mode shadow loads only on a vsync rising edge.
  always_comb begin
    act_d = act_q;
    if (per_frame_vsync && !vsync_q)
      act_d = csc_mode_e'(cfg_mode);
  end

  // Edge-detect register, active mode and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      act_q   <= MODE_601;
      pend_q  <= 1'b0;
    end else begin
      vsync_q <= per_frame_vsync;
      act_q   <= act_d;
      pend_q  <= (cfg_mode != act_d);
    end
  end

  assign std_sel = (act_q == MODE_709);

  vip_csc_row #(.DW(DW), .FRAC(FRAC)) u_row_y (
    .clk(clk), .rst(rst),
    .r_i(per_img_rgb[3*DW-1:2*DW]), .g_i(per_img_rgb[2*DW-1:DW]), .b_i(per_img_rgb[DW-1:0]),
    .c0_i(COEF[std_sel][0][0]), .c1_i(COEF[std_sel][0][1]), .c2_i(COEF[std_sel][0][2]),
    .ofs_en_i(1'b0), .y_o(y_w)
  );

  vip_csc_row #(.DW(DW), .FRAC(FRAC)) u_row_cb (
    .clk(clk), .rst(rst),
    .r_i(per_img_rgb[3*DW-1:2*DW]), .g_i(per_img_rgb[2*DW-1:DW]), .b_i(per_img_rgb[DW-1:0]),
    .c0_i(COEF[std_sel][1][0]), .c1_i(COEF[std_sel][1][1]), .c2_i(COEF[std_sel][1][2]),
    .ofs_en_i(1'b1), .y_o(cb_w)
  );

  vip_csc_row #(.DW(DW), .FRAC(FRAC)) u_row_cr (
    .clk(clk), .rst(rst),
    .r_i(per_img_rgb[3*DW-1:2*DW]), .g_i(per_img_rgb[2*DW-1:DW]), .b_i(per_img_rgb[DW-1:0]),
    .c0_i(COEF[std_sel][2][0]), .c1_i(COEF[std_sel][2][1]), .c2_i(COEF[std_sel][2][2]),
    .ofs_en_i(1'b1), .y_o(cr_w)
  );

  // Output format select and href gating for the final stage.
  always_comb begin
    data_d = '0;
    if (hr_q[LAT-2]) begin
      case (m3_q)
        MODE_601, MODE_709: data_d = {y_w, cb_w, cr_w};
        MODE_GRAY:          data_d = {y_w, y_w, y_w};
        MODE_BYP:           data_d = rgb3_q;
        default:            data_d = '0;
      endcase
    end
  end

  // Mode and raw pixel travel alongside the row pipelines; sync lines shift every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_q   <= MODE_601;
      m2_q   <= MODE_601;
      m3_q   <= MODE_601;
      rgb1_q <= '0;
      rgb2_q <= '0;
      rgb3_q <= '0;
      vs_q   <= '0;
      hr_q   <= '0;
      ce_q   <= '0;
      data_q <= '0;
    end else begin
      m1_q   <= act_q;
      m2_q   <= m1_q;
      m3_q   <= m2_q;
      rgb1_q <= per_img_rgb;
      rgb2_q <= rgb1_q;
      rgb3_q <= rgb2_q;
      vs_q   <= {vs_q[LAT-2:0], per_frame_vsync};
      hr_q   <= {hr_q[LAT-2:0], per_frame_href};
      ce_q   <= {ce_q[LAT-2:0], per_frame_clken};
      data_q <= data_d;
    end
  end

  assign post_frame_vsync = vs_q[LAT-1];
  assign post_frame_href  = hr_q[LAT-1];
  assign post_frame_clken = ce_q[LAT-1];
  assign post_img_data    = data_q;
  assign act_mode         = act_q;
  assign mode_pending     = pend_q;

endmodule

// File: tb/tb_vip_rgb_ycbcr_csc.sv
// Randomised bench for vip_rgb_ycbcr_csc against an arithmetic reference model.
module tb_vip_rgb_ycbcr_csc;

  logic        clk;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic        per_frame_vsync, per_frame_href, per_frame_clken;
  logic [23:0] per_img_rgb;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [23:0] post_img_data;
  logic [1:0]  act_mode;
  logic        mode_pending;

  int n_chk  = 0;
  int n_pass = 0;

  vip_rgb_ycbcr_csc #(.DW(8), .FRAC(8), .LAT(4)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_rgb(per_img_rgb),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_data(post_img_data),
    .act_mode(act_mode), .mode_pending(mode_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model state
  int              act_m;
  bit              pv_m;
  logic [26:0]     hist[$];

  function automatic int conv(int a, int b, int c, int r, int g, int bl, bit ofs);
    int s, v;
    s = a * r + b * g + c * bl + (ofs ? 32768 : 0) + 128;
    v = (s >= 0) ? s / 256 : -((-s + 255) / 256);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic logic [23:0] ref_px(int mode, logic [23:0] p);
    int r, g, b, y, cb, cr;
    logic [7:0] y8, cb8, cr8;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    if (mode == 3) return p;
    if (mode == 2) begin
      y  = conv(54, 183, 18, r, g, b, 1'b0);
      cb = conv(-29, -99, 128, r, g, b, 1'b1);
      cr = conv(128, -116, -12, r, g, b, 1'b1);
    end else begin
      y  = conv(77, 150, 29, r, g, b, 1'b0);
      cb = conv(-43, -85, 128, r, g, b, 1'b1);
      cr = conv(128, -107, -21, r, g, b, 1'b1);
    end
    y8 = 8'(y); cb8 = 8'(cb); cr8 = 8'(cr);
    if (mode == 1) return {y8, y8, y8};
    return {y8, cb8, cr8};
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(27'h0);
    act_m = 0;
    pv_m  = 1'b0;
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit v, input bit h, input bit c, input logic [23:0] p, input logic [1:0] cfg);
    logic [26:0] e;
    per_frame_vsync = v;
    per_frame_href  = h;
    per_frame_clken = c;
    per_img_rgb     = p;
    cfg_mode        = cfg;
    @(posedge clk);
    hist.push_back({v, h, c, (h ? ref_px(act_m, p) : 24'h0)});
    if (v && !pv_m) act_m = int'(cfg);
    pv_m = v;
    @(negedge clk);
    e = hist.pop_front();
    check("sync", {29'b0, post_frame_vsync, post_frame_href, post_frame_clken}, {29'b0, e[26:24]});
    check("data", {8'b0, post_img_data}, {8'b0, e[23:0]});
    check("act_mode", {30'b0, act_mode}, 32'(act_m));
    check("pending", {31'b0, mode_pending}, {31'b0, (cfg != 2'(act_m))});
  endtask

  task automatic steady(input logic [23:0] p, input logic [1:0] cfg, input string tag, input logic [23:0] exp);
    repeat (5) cyc(1'b0, 1'b1, 1'b1, p, cfg);
    check(tag, {8'b0, post_img_data}, {8'b0, exp});
  endtask

  initial begin
    logic [1:0] rcfg;
    rst = 1'b1;
    cfg_mode = 2'd0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_rgb     = 24'h0;
    repeat (2) @(negedge clk);
    check("rst_data", {8'b0, post_img_data}, 32'h0);
    check("rst_sync", {29'b0, post_frame_vsync, post_frame_href, post_frame_clken}, 32'h0);
    check("rst_act", {30'b0, act_mode}, 32'h0);
    check("rst_pend", {31'b0, mode_pending}, 32'h0);
    rst = 1'b0;
    model_reset();

    // BT.601 full-range colours, including Cr saturation
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd0);
    steady(24'hFFFFFF, 2'd0, "t1_white601", 24'hFF8080);
    steady(24'hFF0000, 2'd0, "t2_red601",   24'h4D55FF);

    // Gray mode
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd1);
    check("t3_act_gray", {30'b0, act_mode}, 32'd1);
    steady(24'h000000, 2'd1, "t3_gray_blk", 24'h000000);
    steady(24'hFFFFFF, 2'd1, "t3_gray_wht", 24'hFFFFFF);

    // Bypass
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd3);
    steady(24'h123456, 2'd3, "t3_bypass", 24'h123456);

    // Mid-frame mode request held off until next frame start
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 24'($urandom), 2'd0);
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 24'($urandom), 2'd2);
    check("t4_act_hold", {30'b0, act_mode}, 32'd0);
    check("t4_pending", {31'b0, mode_pending}, 32'd1);
    steady(24'hFF0000, 2'd2, "t4_red_still601", 24'h4D55FF);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd2);
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 2'd2);
    check("t4_act_709", {30'b0, act_mode}, 32'd2);
    check("t4_pend_clr", {31'b0, mode_pending}, 32'd0);
    steady(24'hFF0000, 2'd2, "t4_red709", 24'h3663FF);

    // Random sync patterns, pixels and mode requests
    rcfg = 2'd2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) rcfg = 2'($urandom);
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          24'($urandom), rcfg);
    end

    // Asynchronous reset in the middle of a line
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 2'd3);
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 24'($urandom), 2'd3);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_data", {8'b0, post_img_data}, 32'h0);
    check("t6_rst_sync", {29'b0, post_frame_vsync, post_frame_href, post_frame_clken}, 32'h0);
    check("t6_rst_act", {30'b0, act_mode}, 32'h0);
    check("t6_rst_pend", {31'b0, mode_pending}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) rcfg = 2'($urandom);
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          24'($urandom), rcfg);
    end
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 24'h0, rcfg);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
